oam_dma_sched: RTL and testbench

OAM update scheduler sitting between the CPU/memory side and the PPU's OAM write port (`cpu_oam_data`/`cpu_oam_addr`/`cpu_write`). It performs block DMA copies of sprite records (one 32-bit record per object) from CPU memory into OAM. It also accepts single direct CPU object writes. All OAM writes are confined to cycles where the PPU is not rendering, so sprite attributes never change mid-pixel.

---
 rtl/oam_dma_sched.sv | 143 ++++++++++++++
 tb/tb_oam_dma_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_sched.sv
`timescale 1ns/1ps
// Schedules OAM writes from block DMA copies and direct CPU writes,
// deferring every write to cycles where the PPU is not rendering.
module oam_dma_sched #(
  parameter int MEM_AW  = 16,
  parameter int NUM_OBJ = 64,
  parameter int OBJ_AW  = $clog2(NUM_OBJ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rendering,
  input  logic              dma_start,
  input  logic [MEM_AW-1:0] dma_src,
  input  logic [OBJ_AW-1:0] dma_dst,
  input  logic [OBJ_AW:0]   dma_len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              wr_req,
  input  logic [OBJ_AW-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ack,
  output logic              oam_write,
  output logic [OBJ_AW-1:0] oam_addr,
  output logic [31:0]       oam_data
);

  localparam int LW = OBJ_AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [MEM_AW-1:0] src;
  logic [OBJ_AW-1:0] dst;
  logic [LW-1:0]     len;
  logic [LW-1:0]     issue_cnt;
  logic [LW-1:0]     write_cnt;
  logic              rsp_v;
  logic              hold_v;
  logic [OBJ_AW-1:0] hold_idx;
  logic [31:0]       hold_data;

  logic              issue;
  logic [OBJ_AW-1:0] rsp_idx;
  logic [LW-1:0]     norm_len;

  // The read strobe is combinational so the first read lands one cycle after
  // dma_start; a response that would collide with a direct write blocks the issue.
  always_comb begin
    issue    = (state == RUN) && !rendering && !hold_v && !(rsp_v && wr_req);
    mem_rd   = issue;
    mem_addr = issue ? src + MEM_AW'(issue_cnt) : '0;
    rsp_idx  = dst + OBJ_AW'(write_cnt);
    norm_len = (dma_len == '0 || dma_len > LW'(NUM_OBJ)) ? LW'(NUM_OBJ) : dma_len;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      issue_cnt <= '0;
      write_cnt <= '0;
      rsp_v     <= 1'b0;
      hold_v    <= 1'b0;
      hold_idx  <= '0;
      hold_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ack    <= 1'b0;
      oam_write <= 1'b0;
      oam_addr  <= '0;
      oam_data  <= '0;
    end else begin
      oam_write <= 1'b0;
      wr_ack    <= 1'b0;
      done      <= 1'b0;
      rsp_v     <= issue;

      // Port arbitration: rendering blocks, then direct write, hold, response.
      if (rendering) begin
        if (rsp_v) begin
          hold_v    <= 1'b1;
          hold_idx  <= rsp_idx;
          hold_data <= mem_rdata;
        end
      end else if (wr_req) begin
        oam_write <= 1'b1;
        oam_addr  <= wr_addr;
        oam_data  <= wr_data;
        wr_ack    <= 1'b1;
        if (rsp_v) begin
          hold_v    <= 1'b1;
          hold_idx  <= rsp_idx;
          hold_data <= mem_rdata;
        end
      end else if (hold_v) begin
        oam_write <= 1'b1;
        oam_addr  <= hold_idx;
        oam_data  <= hold_data;
        hold_v    <= 1'b0;
        write_cnt <= write_cnt + LW'(1);
      end else if (rsp_v) begin
        oam_write <= 1'b1;
        oam_addr  <= rsp_idx;
        oam_data  <= mem_rdata;
        write_cnt <= write_cnt + LW'(1);
      end

      case (state)
        IDLE: begin
          if (dma_start) begin
            src       <= dma_src;
            dst       <= dma_dst;
            len       <= norm_len;
            issue_cnt <= '0;
            write_cnt <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            issue_cnt <= issue_cnt + LW'(1);
            if (issue_cnt + LW'(1) == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (write_cnt == len && !rsp_v && !hold_v) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_sched.sv
`timescale 1ns/1ps
// Directed and randomized checks of oam_dma_sched against a record-level
// model: expected DMA write order, read addresses and final OAM image.
module tb_oam_dma_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rendering = 1'b0;
  logic        dma_start = 1'b0;
  logic [15:0] dma_src = '0;
  logic [5:0]  dma_dst = '0;
  logic [6:0]  dma_len = '0;
  logic        busy, done, mem_rd, wr_ack, oam_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        wr_req = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [5:0]  oam_addr;
  logic [31:0] oam_data;

  oam_dma_sched #(.MEM_AW(16), .NUM_OBJ(64)) dut (
    .clk(clk), .reset(reset), .rendering(rendering),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .oam_write(oam_write), .oam_addr(oam_addr), .oam_data(oam_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [0:65535];
  logic [31:0] oam [0:63];
  logic [31:0] exp_oam [0:63];
  logic [31:0] exp_save [0:63];
  wr_t         wq[$];
  logic [15:0] aq[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          dc_start = 0;
  int          cur_len = 0;
  logic [5:0]  cur_dst = '0;
  logic        ren_q = 1'b0;
  logic        req_q = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory with one-cycle read latency, plus the PPU-side OAM latch.
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? mem[mem_addr] : $urandom;
    if (oam_write) oam[oam_addr] <= oam_data;
    ren_q    <= rendering;
    req_q    <= reset & wr_req & ~rendering;
    req_addr <= wr_addr;
    req_data <= wr_data;
  end

  // Per-cycle monitor: ordering of DMA writes, read addresses, rendering rules.
  always @(negedge clk) begin
    if (reset) begin
      wr_t w;
      chk("wr_ack", wr_ack, req_q);
      if (req_q) begin
        chk("direct_write", oam_write, 1);
        chk("direct_addr", oam_addr, req_addr);
        chk("direct_data", oam_data, req_data);
      end
      chk("write_in_render", oam_write & ren_q, 0);
      chk("read_in_render", mem_rd & rendering, 0);
      if (oam_write && !wr_ack) begin
        chk("dma_write_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("dma_idx", oam_addr, w.idx);
          chk("dma_data", oam_data, w.data);
        end
      end
      if (mem_rd) begin
        chk("read_expected", aq.size() > 0, 1);
        if (aq.size() > 0) chk("mem_addr", mem_addr, aq.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_dma(input logic [15:0] src, input logic [5:0] dst, input logic [6:0] len);
    int L;
    wr_t w;
    L = (len == 0 || len > 64) ? 64 : int'(len);
    for (int i = 0; i < L; i++) begin
      w.idx  = dst + 6'(i);
      w.data = mem[src + 16'(i)];
      wq.push_back(w);
      aq.push_back(src + 16'(i));
      exp_oam[w.idx] = w.data;
    end
    dc_start = done_cnt;
    cur_len  = L;
    cur_dst  = dst;
    dma_src = src; dma_dst = dst; dma_len = len; dma_start = 1'b1;
    step();
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int bad;
    for (int i = 0; i < budget && done_cnt == dc_start; i++) step();
    repeat (3) step();
    chk({tag, "_done_once"}, done_cnt - dc_start, 1);
    chk({tag, "_queues_empty"}, wq.size() + aq.size(), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (oam[i] !== exp_oam[i]) bad++;
    chk({tag, "_oam_image"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation timed out");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 64; i++) begin oam[i] = '0; exp_oam[i] = '0; end

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_ctrl", {busy, done, mem_rd, wr_ack, oam_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_oam_data", oam_data, 0);
    step();
    reset = 1'b1;
    step();

    // Basic 4-record latency profile
    start_dma(16'h0100, 6'd0, 7'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("t1_mem_rd_c%0d", c), mem_rd, (c <= 4));
      chk($sformatf("t1_mem_addr_c%0d", c), mem_addr, (c <= 4) ? 16'h0100 + 16'(c - 1) : 16'h0);
      chk($sformatf("t1_oam_write_c%0d", c), oam_write, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk($sformatf("t1_oam_addr_c%0d", c), oam_addr, c - 3);
      chk($sformatf("t1_done_c%0d", c), done, (c == 7));
      chk($sformatf("t1_busy_c%0d", c), busy, (c <= 6));
      step();
    end
    wait_done(10, "t1");

    // len=0 means 64, destination wraps past 63; a start while busy is ignored
    start_dma(16'($urandom), 6'd60, 7'd0);
    repeat (8) step();
    dma_src = 16'h1234; dma_dst = 6'd3; dma_len = 7'd2; dma_start = 1'b1;
    step();
    dma_start = 1'b0;
    wait_done(200, "t2");

    // Source address wrap
    start_dma(16'hFFFE, 6'd7, 7'd3);
    for (int c = 1; c <= 3; c++) begin
      logic [15:0] e;
      e = 16'hFFFE + 16'(c - 1);
      @(negedge clk);
      chk($sformatf("t3_addr_c%0d", c), mem_addr, e);
      step();
    end
    wait_done(20, "t3");

    // Rendering window mid-DMA
    start_dma(16'($urandom), 6'($urandom), 7'd16);
    repeat (4) step();
    rendering = 1'b1;
    repeat (20) step();
    rendering = 1'b0;
    wait_done(100, "t4");

    // Direct write colliding with an arriving DMA response
    start_dma(16'($urandom), 6'd20, 7'd16);
    repeat (3) step();
    wr_req = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF;
    exp_oam[5] = 32'hDEADBEEF;
    step();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t5_ack", wr_ack, 1);
    chk("t5_addr", oam_addr, 5);
    chk("t5_data", oam_data, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t5_parked_write", {oam_write, wr_ack}, 2'b10);
    chk("t5_parked_idx", oam_addr, 22);
    wait_done(100, "t5");

    // Asynchronous reset during the third record of an 8-record DMA
    exp_save = exp_oam;
    begin
      logic [15:0] s;
      s = 16'($urandom);
      start_dma(s, 6'd40, 7'd8);
      repeat (4) step();
      #1;
      reset = 1'b0;
      #1;
      chk("t6_async_ctrl", {busy, done, mem_rd, wr_ack, oam_write}, 0);
      chk("t6_async_addr", {mem_addr, oam_addr}, 0);
      chk("t6_async_data", oam_data, 0);
      wq.delete();
      aq.delete();
      exp_oam = exp_save;
      exp_oam[40] = mem[s];
      exp_oam[41] = mem[s + 16'd1];
    end
    repeat (3) step();
    reset = 1'b1;
    repeat (15) step();
    chk("t6_no_done", done_cnt - dc_start, 0);
    start_dma(16'($urandom), 6'd50, 7'd8);
    wait_done(40, "t6");

    // Randomized DMAs with rendering bursts, direct writes and ignored starts
    for (int t = 0; t < 10; t++) begin
      int ren_left;
      ren_left = 0;
      start_dma(16'($urandom), 6'($urandom), 7'($urandom_range(0, 80)));
      for (int cyc = 0; cyc < 600 && done_cnt == dc_start; cyc++) begin
        if (ren_left > 0) begin
          rendering = 1'b1;
          ren_left--;
        end else begin
          rendering = 1'b0;
          if ($urandom_range(0, 7) == 0) ren_left = $urandom_range(1, 6);
        end
        wr_req = 1'b0;
        if (!rendering && cur_len < 64 && $urandom_range(0, 9) == 0) begin
          wr_req  = 1'b1;
          wr_addr = cur_dst + 6'(cur_len) + 6'($urandom_range(0, 63 - cur_len));
          wr_data = $urandom;
          exp_oam[wr_addr] = wr_data;
        end
        dma_start = busy && ($urandom_range(0, 15) == 0);
        dma_src = 16'($urandom); dma_dst = 6'($urandom); dma_len = 7'($urandom);
        step();
      end
      rendering = 1'b0; wr_req = 1'b0; dma_start = 1'b0;
      wait_done(50, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
